// File: rtl/mig_arb_pkg.sv
// Shared constants and types for the MIG user-port arbiter.
package mig_arb_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 27;
  localparam int unsigned DEF_DATA_WIDTH = 128;
  localparam int unsigned DEF_MASK_WIDTH = 16;

  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;

  typedef enum logic {
    ARB_IDLE,
    ARB_ISSUE
  } arb_state_t;

endpackage

// File: rtl/mig_tag_fifo.sv
// In-order FIFO of requester ids for reads waiting on MIG return data.
module mig_tag_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (count == (AW+1)'(DEPTH));
  assign empty_c = (count == '0);
  assign head_c  = mem[rd_ptr];
  assign do_push = push & ~full_c;
  assign do_pop  = pop & ~empty_c;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mig_port_arbiter.sv
// Round-robin sharing of the MIG user port between NUM_REQ single-beat requesters,
// with read returns steered back to their issuer through an in-order tag FIFO.
module mig_port_arbiter
  import mig_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MASK_WIDTH = DEF_MASK_WIDTH,
  parameter int unsigned TAG_DEPTH  = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             init_calib_complete,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*MASK_WIDTH-1:0]    req_wmask,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rd_valid,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             err_unexpected_rd,
  output logic                             app_en,
  output logic [2:0]                       app_cmd,
  output logic [ADDR_WIDTH-1:0]            app_addr,
  output logic [DATA_WIDTH-1:0]            app_wdf_data,
  output logic [MASK_WIDTH-1:0]            app_wdf_mask,
  output logic                             app_wdf_wren,
  output logic                             app_wdf_end,
  input  logic                             app_rdy,
  input  logic                             app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]            app_rd_data,
  input  logic                             app_rd_data_valid
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t        state, state_d;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_d;
  logic [ID_W-1:0]   gnt_id, gnt_id_d;
  logic [NUM_REQ-1:0] req_ready_d;
  logic              app_en_d, app_wdf_wren_d, app_wdf_end_d;
  logic [2:0]        app_cmd_d;
  logic [ADDR_WIDTH-1:0] app_addr_d;
  logic [DATA_WIDTH-1:0] app_wdf_data_d;
  logic [MASK_WIDTH-1:0] app_wdf_mask_d;

  logic              pick_found_c;
  logic [ID_W-1:0]   pick_id_c;
  logic              cmd_done_c, wdf_done_c;
  logic              tag_push_c, tag_pop_c, tag_full_c, tag_empty_c;
  logic [ID_W-1:0]   tag_head_c;
  logic [NUM_REQ-1:0] rd_onehot_c;

  // Each side is done once its enable has dropped or is being accepted this cycle.
  assign cmd_done_c = ~app_en | app_rdy;
  assign wdf_done_c = ~app_wdf_wren | app_wdf_rdy;
  assign tag_push_c = (state == ARB_ISSUE) & app_en & app_rdy & (app_cmd == MIG_CMD_READ);
  assign tag_pop_c  = app_rd_data_valid & ~tag_empty_c;

  mig_tag_fifo #(
    .WIDTH (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tag_push_c),
    .push_data (gnt_id),
    .pop       (tag_pop_c),
    .head_c    (tag_head_c),
    .full_c    (tag_full_c),
    .empty_c   (tag_empty_c)
  );

  // Round-robin scan from rr_ptr; reads are skipped while no tag slot is free.
  always_comb begin
    pick_found_c = 1'b0;
    pick_id_c    = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ] &&
          (req_we[(int'(rr_ptr) + k) % NUM_REQ] || !tag_full_c)) begin
        pick_found_c = 1'b1;
        pick_id_c    = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ARB_IDLE;
      rr_ptr       <= '0;
      gnt_id       <= '0;
      req_ready    <= '0;
      app_en       <= 1'b0;
      app_cmd      <= '0;
      app_addr     <= '0;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_end  <= 1'b0;
    end else begin
      state        <= state_d;
      rr_ptr       <= rr_ptr_d;
      gnt_id       <= gnt_id_d;
      req_ready    <= req_ready_d;
      app_en       <= app_en_d;
      app_cmd      <= app_cmd_d;
      app_addr     <= app_addr_d;
      app_wdf_data <= app_wdf_data_d;
      app_wdf_mask <= app_wdf_mask_d;
      app_wdf_wren <= app_wdf_wren_d;
      app_wdf_end  <= app_wdf_end_d;
    end
  end

  always_comb begin
    state_d        = state;
    rr_ptr_d       = rr_ptr;
    gnt_id_d       = gnt_id;
    req_ready_d    = '0;
    app_en_d       = app_en;
    app_cmd_d      = app_cmd;
    app_addr_d     = app_addr;
    app_wdf_data_d = app_wdf_data;
    app_wdf_mask_d = app_wdf_mask;
    app_wdf_wren_d = app_wdf_wren;
    app_wdf_end_d  = app_wdf_end;
    case (state)
      ARB_IDLE: begin
        if (init_calib_complete && pick_found_c) begin
          state_d                = ARB_ISSUE;
          gnt_id_d               = pick_id_c;
          rr_ptr_d               = (pick_id_c == ID_W'(NUM_REQ - 1)) ? '0 : pick_id_c + ID_W'(1);
          req_ready_d[pick_id_c] = 1'b1;
          app_en_d               = 1'b1;
          app_cmd_d              = req_we[pick_id_c] ? MIG_CMD_WRITE : MIG_CMD_READ;
          app_addr_d             = req_addr[int'(pick_id_c) * ADDR_WIDTH +: ADDR_WIDTH];
          app_wdf_data_d         = req_wdata[int'(pick_id_c) * DATA_WIDTH +: DATA_WIDTH];
          app_wdf_mask_d         = req_wmask[int'(pick_id_c) * MASK_WIDTH +: MASK_WIDTH];
          app_wdf_wren_d         = req_we[pick_id_c];
          app_wdf_end_d          = req_we[pick_id_c];
        end
      end
      ARB_ISSUE: begin
        if (app_en && app_rdy) app_en_d = 1'b0;
        if (app_wdf_wren && app_wdf_rdy) begin
          app_wdf_wren_d = 1'b0;
          app_wdf_end_d  = 1'b0;
        end
        if (cmd_done_c && wdf_done_c) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    rd_onehot_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      rd_onehot_c[i] = (tag_head_c == ID_W'(i));
    end
  end

  // Read-return steering and the sticky no-tag error.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid          <= '0;
      rd_data           <= '0;
      err_unexpected_rd <= 1'b0;
    end else begin
      rd_valid <= '0;
      if (tag_pop_c) begin
        rd_valid <= rd_onehot_c;
        rd_data  <= app_rd_data;
      end
      if (app_rd_data_valid && tag_empty_c) err_unexpected_rd <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mig_port_arbiter.sv
// Self-checking bench for mig_port_arbiter: vector table plus multi-cycle sequences.
module tb_mig_port_arbiter;
  import mig_arb_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 27;
  localparam int unsigned DW = 128;
  localparam int unsigned MW = 16;

  logic clk = 1'b0;
  logic reset, init_calib_complete;
  logic [NR-1:0]    req_valid, req_we, req_ready, rd_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR*MW-1:0] req_wmask;
  logic [DW-1:0]    rd_data, app_wdf_data, app_rd_data;
  logic             err_unexpected_rd, app_en, app_wdf_wren, app_wdf_end;
  logic [2:0]       app_cmd;
  logic [AW-1:0]    app_addr;
  logic [MW-1:0]    app_wdf_mask;
  logic             app_rdy, app_wdf_rdy, app_rd_data_valid;

  mig_port_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .TAG_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .init_calib_complete(init_calib_complete),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .err_unexpected_rd(err_unexpected_rd),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        we;
    logic [26:0] addr;
    logic [127:0] data;
    logic [15:0] mask;
  } cmd_t;

  typedef struct {
    int           id;
    logic [127:0] data;
  } rd_t;

  typedef struct {
    int           id;
    logic         we;
    logic [26:0]  addr;
    logic [127:0] data;
    logic [15:0]  mask;
    int           rdy_dly;
    int           wdf_dly;
    int           exp_en;
    int           exp_wr;
  } vec_t;

  cmd_t exp_cmd_q[$];
  cmd_t exp_wdf_q[$];
  rd_t  exp_rd_q[$];
  int   tag_q[$];
  int   grant_q[$];
  int   rq_left[NR];
  logic [26:0] rq_addr[NR];
  int   ready_seen[NR];
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int id);
    logic [1:0] r;
    r = '0;
    r[id] = 1'b1;
    return r;
  endfunction

  // Inputs for the coming posedge are already set; score handshakes, then advance.
  task automatic tick();
    cmd_t c;
    rd_t  r;
    if (exp_rd_q.size() > 0) begin
      r = exp_rd_q.pop_front();
      chk("rd_valid", 128'(rd_valid), 128'(onehot(r.id)));
      chk("rd_data", rd_data, r.data);
    end else if (rd_valid != '0) begin
      chk("rd_valid_spurious", 128'(rd_valid), 128'(0));
    end
    if (req_ready != '0) begin
      chk("req_ready_onehot", 128'($onehot(req_ready)), 128'(1));
      for (int i = 0; i < int'(NR); i++) begin
        if (req_ready[i]) begin
          grant_q.push_back(i);
          ready_seen[i]++;
          rq_left[i]--;
          rq_addr[i]++;
          req_addr[i*AW +: AW] = rq_addr[i];
          if (rq_left[i] <= 0) req_valid[i] = 1'b0;
        end
      end
    end
    if (app_rd_data_valid && tag_q.size() > 0) begin
      r.id   = tag_q.pop_front();
      r.data = app_rd_data;
      exp_rd_q.push_back(r);
    end
    if (app_en && app_rdy) begin
      if (exp_cmd_q.size() == 0) chk("cmd_unexpected", 128'(app_en), 128'(0));
      else begin
        c = exp_cmd_q.pop_front();
        chk("app_cmd", 128'(app_cmd), 128'(c.we ? MIG_CMD_WRITE : MIG_CMD_READ));
        chk("app_addr", 128'(app_addr), 128'(c.addr));
        if (!c.we) tag_q.push_back(c.id);
      end
    end
    if (app_wdf_wren && app_wdf_rdy) begin
      if (exp_wdf_q.size() == 0) chk("wdf_unexpected", 128'(app_wdf_wren), 128'(0));
      else begin
        c = exp_wdf_q.pop_front();
        chk("app_wdf_data", app_wdf_data, c.data);
        chk("app_wdf_mask", 128'(app_wdf_mask), 128'(c.mask));
        chk("app_wdf_end", 128'(app_wdf_end), 128'(1));
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    req_we = '0;
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    app_rd_data_valid = 1'b0;
    exp_cmd_q.delete(); exp_wdf_q.delete(); exp_rd_q.delete();
    tag_q.delete(); grant_q.delete();
    for (int i = 0; i < int'(NR); i++) begin
      rq_left[i] = 0;
      ready_seen[i] = 0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_app_en"}, 128'(app_en), 128'(0));
    chk({tag, "_wren_end"}, 128'({app_wdf_wren, app_wdf_end}), 128'(0));
    chk({tag, "_app_cmd"}, 128'(app_cmd), 128'(0));
    chk({tag, "_app_addr"}, 128'(app_addr), 128'(0));
    chk({tag, "_wdf_data"}, app_wdf_data, 128'(0));
    chk({tag, "_wdf_mask"}, 128'(app_wdf_mask), 128'(0));
    chk({tag, "_req_ready"}, 128'(req_ready), 128'(0));
    chk({tag, "_rd_valid"}, 128'(rd_valid), 128'(0));
    chk({tag, "_rd_data"}, rd_data, 128'(0));
    chk({tag, "_err"}, 128'(err_unexpected_rd), 128'(0));
  endtask

  task automatic set_req(input int id, input logic we, input logic [26:0] addr,
                         input logic [127:0] data, input logic [15:0] mask, input int n);
    rq_left[id] = n;
    rq_addr[id] = addr;
    req_addr[id*AW +: AW] = addr;
    req_we[id] = we;
    req_wdata[id*DW +: DW] = data;
    req_wmask[id*MW +: MW] = mask;
    req_valid[id] = 1'b1;
  endtask

  initial begin
    cmd_t c;
    vec_t v;
    int   en_cnt, wr_cnt, cyc, seen;

    vecs[0] = '{0, 1'b1, 27'h008, {8{16'h0001}}, 16'h0000, 0, 0, 1, 1};
    vecs[1] = '{1, 1'b0, 27'h1234, 128'h0, 16'h0000, 2, 0, 3, 0};
    vecs[2] = '{0, 1'b1, 27'h7FF_FFFF, {4{32'hCAFE_F00D}}, 16'hF0F0, 0, 3, 1, 4};
    vecs[3] = '{1, 1'b1, 27'h0055, {2{64'h0123_4567_89AB_CDEF}}, 16'h0001, 2, 0, 3, 1};
    vecs[4] = '{0, 1'b0, 27'h2000, 128'h0, 16'h0000, 0, 0, 1, 0};

    init_calib_complete = 1'b0;
    req_addr = '0; req_wdata = '0; req_wmask = '0;
    app_rd_data = '0;
    do_reset();
    chk_reset_outputs("reset");

    // Single transactions with assorted handshake delays
    init_calib_complete = 1'b1;
    for (int n = 0; n < 5; n++) begin
      v = vecs[n];
      c.id = v.id; c.we = v.we; c.addr = v.addr; c.data = v.data; c.mask = v.mask;
      exp_cmd_q.push_back(c);
      if (v.we) exp_wdf_q.push_back(c);
      for (int i = 0; i < int'(NR); i++) ready_seen[i] = 0;
      set_req(v.id, v.we, v.addr, v.data, v.mask, 1);
      app_rdy = 1'b0;
      app_wdf_rdy = 1'b0;
      tick();
      chk("grant_latency", 128'(req_ready), 128'(onehot(v.id)));
      chk("app_en_latency", 128'(app_en), 128'(1));
      en_cnt = 0;
      wr_cnt = 0;
      for (int k = 0; k < 30 && (app_en || app_wdf_wren); k++) begin
        app_rdy = app_en && (en_cnt >= v.rdy_dly);
        app_wdf_rdy = app_wdf_wren && (wr_cnt >= v.wdf_dly);
        if (app_en) en_cnt++;
        if (app_wdf_wren) wr_cnt++;
        tick();
      end
      app_rdy = 1'b0;
      app_wdf_rdy = 1'b0;
      chk("vec_en_cycles", 128'(en_cnt), 128'(v.exp_en));
      chk("vec_wren_cycles", 128'(wr_cnt), 128'(v.exp_wr));
      chk("vec_ready_pulses", 128'(ready_seen[v.id]), 128'(1));
      chk("vec_cmd_drained", 128'(exp_cmd_q.size() + exp_wdf_q.size()), 128'(0));
      tick();
    end

    // Round-robin reads from both requesters, then in-order returns
    do_reset();
    init_calib_complete = 1'b1;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      c.id = k % 2; c.we = 1'b0; c.data = '0; c.mask = '0;
      c.addr = 27'((k % 2 == 0 ? 'h100 : 'h200) + k / 2);
      exp_cmd_q.push_back(c);
    end
    set_req(0, 1'b0, 27'h100, '0, '0, 2);
    set_req(1, 1'b0, 27'h200, '0, '0, 2);
    cyc = 0;
    while (cyc < 40 && grant_q.size() < 4) begin
      tick();
      cyc++;
    end
    tick();
    chk("rr_grants", 128'(grant_q.size()), 128'(4));
    for (int k = 0; k < 4 && k < grant_q.size(); k++) chk("rr_order", 128'(grant_q[k]), 128'(k % 2));
    chk("rr_cycles", 128'(cyc), 128'(8));
    chk("rr_cmds_drained", 128'(exp_cmd_q.size()), 128'(0));
    for (int k = 0; k < 4; k++) begin
      app_rd_data_valid = 1'b1;
      app_rd_data = 128'(k + 10);
      tick();
    end
    app_rd_data_valid = 1'b0;
    tick();
    tick();
    chk("rr_returns_drained", 128'(exp_rd_q.size() + tag_q.size()), 128'(0));
    chk("rr_no_err", 128'(err_unexpected_rd), 128'(0));

    // Tag FIFO full blocks the ninth read until one return arrives
    do_reset();
    init_calib_complete = 1'b1;
    app_rdy = 1'b1;
    for (int k = 0; k < 9; k++) begin
      c.id = 0; c.we = 1'b0; c.data = '0; c.mask = '0; c.addr = 27'(32'h300 + k);
      exp_cmd_q.push_back(c);
    end
    set_req(0, 1'b0, 27'h300, '0, '0, 9);
    repeat (40) tick();
    chk("full_grants", 128'(grant_q.size()), 128'(8));
    chk("full_cmd_left", 128'(exp_cmd_q.size()), 128'(1));
    chk("full_ready_low", 128'(req_ready), 128'(0));
    app_rd_data_valid = 1'b1;
    app_rd_data = 128'hFEED;
    tick();
    app_rd_data_valid = 1'b0;
    for (int k = 0; k < 10 && grant_q.size() < 9; k++) tick();
    tick();
    chk("full_ninth_grant", 128'(grant_q.size()), 128'(9));
    chk("full_cmd_drained", 128'(exp_cmd_q.size()), 128'(0));

    // Calibration gating
    do_reset();
    init_calib_complete = 1'b0;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    c.id = 1; c.we = 1'b1; c.addr = 27'h40; c.data = {4{32'hDEAD_BEEF}}; c.mask = 16'h00FF;
    exp_cmd_q.push_back(c);
    exp_wdf_q.push_back(c);
    set_req(1, 1'b1, c.addr, c.data, c.mask, 1);
    seen = 0;
    repeat (100) begin
      tick();
      if (app_en || req_ready != '0) seen++;
    end
    chk("calib_gate", 128'(seen), 128'(0));
    init_calib_complete = 1'b1;
    tick();
    chk("calib_grant_ready", 128'(req_ready), 128'(2'b10));
    chk("calib_grant_en", 128'(app_en), 128'(1));
    tick();
    tick();
    chk("calib_drained", 128'(exp_cmd_q.size() + exp_wdf_q.size()), 128'(0));

    // Unexpected read data, reset during a read ISSUE, then stray data again
    do_reset();
    init_calib_complete = 1'b1;
    app_rd_data_valid = 1'b1;
    app_rd_data = 128'h1111;
    tick();
    app_rd_data_valid = 1'b0;
    chk("err_set", 128'(err_unexpected_rd), 128'(1));
    tick();
    set_req(0, 1'b0, 27'h0AB_CDEF, {4{32'h5555_AAAA}}, 16'h5A5A, 1);
    repeat (3) tick();
    chk("issue_hold_en", 128'(app_en), 128'(1));
    chk("issue_hold_cmd", 128'(app_cmd), 128'(MIG_CMD_READ));
    reset = 1'b1;
    req_valid = '0;
    exp_cmd_q.delete();
    tag_q.delete();
    @(negedge clk);
    reset = 1'b0;
    chk_reset_outputs("midreset");
    app_rd_data_valid = 1'b1;
    app_rd_data = 128'h2222;
    tick();
    app_rd_data_valid = 1'b0;
    chk("err_after_reset", 128'(err_unexpected_rd), 128'(1));
    chk("no_rd_after_reset", 128'(rd_valid), 128'(0));
    tick();
    chk("err_sticky", 128'(err_unexpected_rd), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
